// File: rtl/ordena_n_ctrl.sv
// Block sorter: loads N words, runs N odd-even transposition passes through one
// external compare-swap unit (one pair per cycle), then streams the result out.
module ordena_n_ctrl #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         cresc_ou_decres,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic         done,
  output logic         cs_ena,
  output logic         cs_cresc,
  output logic [W-1:0] cs_n1,
  output logic [W-1:0] cs_n2,
  input  logic [W-1:0] cs_menor,
  input  logic [W-1:0] cs_maior
);

  localparam int CW = $clog2(N + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SORT = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  idx_reg, idx_next;
  logic [CW-1:0]  pass_reg, pass_next;
  logic [CW-1:0]  pass_inc;
  logic           dir_reg, dir_next;
  logic           done_reg, done_next;

  logic [W-1:0]   mem [N];
  logic [IW-1:0]  idx_w;
  logic [IW-1:0]  idx_p1;
  logic           last_word;
  logic           pair_last;

  assign idx_w     = idx_reg[IW-1:0];
  assign idx_p1    = idx_w + IW'(1);
  assign last_word = (int'(idx_reg) == N - 1);
  // Current pair (i, i+1) is the last of its pass when i+2 would run past N-1.
  assign pair_last = (int'(idx_reg) + 3 >= N);

  // With N=2 every odd pass is empty, so it is skipped outright.
  always_comb begin
    if (!pass_reg[0] && (N < 3)) pass_inc = pass_reg + CW'(2);
    else                         pass_inc = pass_reg + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      pass_reg  <= '0;
      dir_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      pass_reg  <= pass_next;
      dir_reg   <= dir_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    pass_next  = pass_reg;
    dir_next   = dir_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          dir_next   = cresc_ou_decres;
          idx_next   = '0;
          pass_next  = '0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          if (last_word) begin
            state_next = SORT;
            idx_next   = '0;
            pass_next  = '0;
          end else begin
            idx_next = idx_reg + CW'(1);
          end
        end
      end
      SORT: begin
        if (pair_last) begin
          if (int'(pass_inc) >= N) begin
            state_next = OUT;
            idx_next   = '0;
            pass_next  = '0;
          end else begin
            pass_next = pass_inc;
            idx_next  = pass_inc[0] ? CW'(1) : '0;
          end
        end else begin
          idx_next = idx_reg + CW'(2);
        end
      end
      OUT: begin
        if (out_ready) begin
          if (last_word) begin
            state_next = IDLE;
            idx_next   = '0;
            done_next  = 1'b1;
          end else begin
            idx_next = idx_reg + CW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == LOAD);
    out_valid = (state_reg == OUT);
    busy      = (state_reg != IDLE);
    cs_ena    = (state_reg == SORT);
    cs_cresc  = dir_reg;
    done      = done_reg;
    out_data  = '0;
    cs_n1     = '0;
    cs_n2     = '0;
    if (state_reg == OUT) out_data = mem[idx_w];
    // Zeroed operands outside SORT keep the shared unit in passthrough.
    if (state_reg == SORT) begin
      cs_n1 = mem[idx_w];
      cs_n2 = mem[idx_p1];
    end
  end

  // Word store has no reset: its contents are only read after a full load.
  always_ff @(posedge clk) begin
    if (state_reg == LOAD && in_valid) begin
      mem[idx_w] <= in_data;
    end else if (state_reg == SORT) begin
      mem[idx_w]  <= cs_menor;
      mem[idx_p1] <= cs_maior;
    end
  end

endmodule

// File: tb/tb_ordena_n_ctrl.sv
// Bench for ordena_n_ctrl: an N=4 and an N=8 instance, each with a behavioural
// compare-swap unit, checked against a queue-sort reference of every block.
module tb_ordena_n_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [1:0]      start, dir, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]      busy, done, cs_ena, cs_cresc;
  logic [1:0][7:0] in_data, out_data, cs_n1, cs_n2, cs_menor, cs_maior;

  int n_cmp = 0;
  int n_err = 0;

  ordena_n_ctrl #(.N(4), .W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .cresc_ou_decres(dir[0]),
    .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
    .out_valid(out_valid[0]), .out_data(out_data[0]), .out_ready(out_ready[0]),
    .busy(busy[0]), .done(done[0]), .cs_ena(cs_ena[0]), .cs_cresc(cs_cresc[0]),
    .cs_n1(cs_n1[0]), .cs_n2(cs_n2[0]), .cs_menor(cs_menor[0]), .cs_maior(cs_maior[0])
  );

  ordena_n_ctrl #(.N(8), .W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .cresc_ou_decres(dir[1]),
    .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
    .out_valid(out_valid[1]), .out_data(out_data[1]), .out_ready(out_ready[1]),
    .busy(busy[1]), .done(done[1]), .cs_ena(cs_ena[1]), .cs_cresc(cs_cresc[1]),
    .cs_n1(cs_n1[1]), .cs_n2(cs_n2[1]), .cs_menor(cs_menor[1]), .cs_maior(cs_maior[1])
  );

  // Compare-swap unit: passthrough when idle, otherwise orders the pair.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      cs_menor[d] = cs_n1[d];
      cs_maior[d] = cs_n2[d];
      if (cs_ena[d]) begin
        if (cs_cresc[d] ? (cs_n1[d] >= cs_n2[d]) : (cs_n1[d] <= cs_n2[d])) begin
          cs_menor[d] = cs_n2[d];
          cs_maior[d] = cs_n1[d];
        end
      end
    end
  end

  function automatic int sort_cycles(input int n);
    int s = 0;
    for (int p = 0; p < n; p++) s += (p % 2 == 0) ? n / 2 : (n - 1) / 2;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_block(input int d, input logic dr, input int data[$],
                           input int gap_pct, input int stall_pct,
                           input bit poke_start, input string tag);
    int nn;
    int expq[$];
    int cyc;
    int k;
    nn = (d == 0) ? 4 : 8;
    expq = data;
    if (dr) expq.sort();
    else    expq.rsort();
    $display("block %s: dut N=%0d dir=%0d data=%p expect=%p", tag, nn, dr, data, expq);
    chk({tag, " idle busy"}, 32'(busy[d]), 32'd0);
    start[d] = 1'b1;
    dir[d]   = dr;
    @(negedge clk);
    start[d] = 1'b0;
    dir[d]   = ~dr;
    chk({tag, " load busy"}, 32'(busy[d]), 32'd1);
    chk({tag, " load in_ready"}, 32'(in_ready[d]), 32'd1);
    for (int i = 0; i < nn; ) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        in_valid[d] = 1'b0;
        in_data[d]  = 8'($urandom);
      end else begin
        in_valid[d] = 1'b1;
        in_data[d]  = 8'(data[i]);
        i++;
      end
      @(negedge clk);
    end
    in_valid[d] = 1'b0;
    chk({tag, " sort in_ready"}, 32'(in_ready[d]), 32'd0);
    chk({tag, " sort cs_cresc"}, 32'(cs_cresc[d]), 32'(dr));
    cyc = 0;
    while (cs_ena[d] === 1'b1 && cyc < 100) begin
      start[d] = (poke_start && cyc == 1);
      if (poke_start) chk({tag, " sort busy"}, 32'(busy[d]), 32'd1);
      cyc++;
      @(negedge clk);
    end
    start[d] = 1'b0;
    chk({tag, " sort cycles"}, 32'(cyc), 32'(sort_cycles(nn)));
    chk({tag, " out busy"}, 32'(busy[d]), 32'd1);
    chk({tag, " out cs_n1 idle"}, 32'(cs_n1[d]), 32'd0);
    k = 0;
    cyc = 0;
    while (k < nn && cyc < 500) begin
      chk({tag, " out_valid"}, 32'(out_valid[d]), 32'd1);
      chk({tag, " out_data"}, 32'(out_data[d]), 32'(expq[k]));
      out_ready[d] = ($urandom_range(0, 99) >= stall_pct);
      @(negedge clk);
      if (out_ready[d]) k++;
      cyc++;
    end
    out_ready[d] = 1'b0;
    chk({tag, " words out"}, 32'(k), 32'(nn));
    chk({tag, " done pulse"}, 32'(done[d]), 32'd1);
    chk({tag, " end busy"}, 32'(busy[d]), 32'd0);
    chk({tag, " end out_valid"}, 32'(out_valid[d]), 32'd0);
    @(negedge clk);
    chk({tag, " done low"}, 32'(done[d]), 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, " busy"}, 32'(busy[d]), 32'd0);
      chk({tag, " done"}, 32'(done[d]), 32'd0);
      chk({tag, " out_valid"}, 32'(out_valid[d]), 32'd0);
      chk({tag, " in_ready"}, 32'(in_ready[d]), 32'd0);
      chk({tag, " cs_ena"}, 32'(cs_ena[d]), 32'd0);
      chk({tag, " cs_cresc"}, 32'(cs_cresc[d]), 32'd0);
      chk({tag, " cs_n1"}, 32'(cs_n1[d]), 32'd0);
      chk({tag, " cs_n2"}, 32'(cs_n2[d]), 32'd0);
    end
  endtask

  int q[$];

  initial begin
    rst_n     = 1'b0;
    start     = '0;
    dir       = '0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = '0;
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    q = '{9, 3, 7, 1};
    run_block(0, 1'b1, q, 0, 0, 1'b0, "t1_asc");
    run_block(0, 1'b0, q, 0, 0, 1'b0, "t2_desc");
    q = '{5, 5, 2, 5};
    run_block(0, 1'b1, q, 40, 50, 1'b0, "t3_gaps");
    q = '{255, 0, 128, 1, 254, 2, 127, 3};
    run_block(1, 1'b1, q, 0, 0, 1'b0, "t4_n8");
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(int'($urandom_range(0, 255)));
    run_block(1, 1'b0, q, 20, 20, 1'b1, "t5_poke");

    // Asynchronous reset in the middle of SORT.
    $display("block t6_reset: reset asserted mid-sort on N=4");
    start[0] = 1'b1;
    dir[0]   = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 8'($urandom);
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("t6 pre-reset cs_ena", 32'(cs_ena[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_state("t6 async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    q = '{200, 17, 99, 42};
    run_block(0, 1'b1, q, 0, 0, 1'b0, "t6_after");

    for (int r = 0; r < 10; r++) begin
      int d;
      int nn;
      d  = r % 2;
      nn = (d == 0) ? 4 : 8;
      q.delete();
      for (int i = 0; i < nn; i++) q.push_back(int'($urandom_range(0, 255)));
      run_block(d, 1'($urandom_range(0, 1)), q, 30, 30, 1'b0, $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
